fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage plus IF/ID pipeline register; consumes stall_IF, stall_ID, flush_ID, PCSrc_EX from hazard control.
//  Owns PC, issues fetches to a variable-latency instruction memory (max one outstanding).
//  Delivers instr/PC to ID; inserts NOP bubbles on flush and on fetch latency.
// PARAMETERS
//  XLEN       32            datapath / address width
//  RESET_PC   32'h0000_0000 PC value after reset
//  NOP_INSTR  32'h0000_0013 bubble encoding (addi x0,x0,0)
// PORTS
//  clk             in   1     clock, rising edge
//  rst             in   1     asynchronous reset, active-high
//  stall_IF        in   1     hold PC, issue no new fetch
//  stall_ID        in   1     hold IF/ID register
//  flush_ID        in   1     load bubble into IF/ID register
//  PCSrc_EX        in   1     taken branch/jump resolved in EX
//  PCTarget_EX     in   XLEN  redirect target
//  imem_req_valid  out  1     fetch request
//  imem_req_ready  in   1     memory accepts request
//  imem_addr       out  XLEN  fetch address (= pc_IF)
//  imem_rsp_valid  in   1     instruction returned (no backpressure)
//  imem_rsp_data   in   32    instruction word
//  instr_ID        out  32    instruction to decode
//  pc_ID           out  XLEN  PC of instr_ID
//  pc_plus4_ID     out  XLEN  pc_ID + 4
//  valid_ID        out  1     instr_ID is real (0 = bubble)
// BEHAVIOUR
//  Reset: pc_IF=RESET_PC, state=IDLE, buffer empty, instr_ID=NOP_INSTR, pc_ID=0, pc_plus4_ID=0, valid_ID=0.
//  States: IDLE (no request outstanding), WAIT (accepted, awaiting response), DROP (awaiting stale response).
//  imem_req_valid = IDLE & !buf_valid & !stall_IF & !PCSrc_EX (combinational); imem samples only on valid&ready,
//   no stability requirement on withdrawn requests.
//  Request handshake: pc_req<=pc_IF, pc_IF<=pc_IF+4 (mod 2^XLEN wrap), IDLE->WAIT.
//  Redirect (PCSrc_EX=1): pc_IF<=PCTarget_EX, priority over stall_IF; WAIT->DROP; buffer cleared.
//  WAIT & imem_rsp_valid: ->IDLE; word goes to IF/ID if !stall_ID & !flush_ID, else into 1-entry buffer
//   (with pc_req); if PCSrc_EX same cycle the word is discarded.
//  DROP & imem_rsp_valid: word discarded, ->IDLE. Response in IDLE is illegal (assert).
//  IF/ID update priority: flush_ID -> bubble (NOP_INSTR, valid_ID=0, pc_ID/pc_plus4_ID hold);
//   else stall_ID -> hold all; else buffer full -> load buffer, clear it;
//   else WAIT&rsp_valid -> load response; else bubble.
//  Load sets valid_ID=1, pc_ID=pc_req (or buffered PC), pc_plus4_ID=pc_ID+4.
//  Buffer blocks new issue, so program order is preserved; never overflows (one outstanding).
//  Reset mid-request: state to IDLE; any later stale response arrives in IDLE -> memory must be reset with core.
//  Latency: request accepted cycle N, response cycle M>=N+1 -> valid in ID at M+1 (no stall).
// STRUCTURE
//  riscv_pkg: NOP_INSTR constant, fetch_state_t enum {IDLE,WAIT,DROP}.
//  Sub-module fetch_skid_buf: 1-entry {instr,pc} buffer with load/clear/valid.
//  PC register, FSM and IF/ID register stay in fetch_stage.
// TESTING
//  Reset, imem ready=1, 1-cycle rsp: imem_addr 0x0,0x4,0x8 on alternate cycles; valid_ID pulses, pc_ID follows.
//  stall_ID held 3 cycles while rsp for 0x4 returns -> word buffered, instr_ID holds; release -> 0x4 loads next edge.
//  PCSrc_EX=1, PCTarget_EX=0x100 while WAIT on 0x8 -> rsp for 0x8 dropped, next imem_addr=0x100, valid_ID=0 in between.
//  flush_ID and stall_ID both high -> bubble: instr_ID=0x00000013, valid_ID=0.
//  stall_IF high, imem_req_ready=0 -> imem_req_valid=0, pc_IF stays; PCSrc_EX during stall_IF -> pc_IF=target.
//  pc_IF=0xFFFF_FFFC, request accepted -> pc_IF wraps to 0x0; rst asserted mid-WAIT -> all outputs reset values.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants.
// Bubble encoding and fetch FSM states.
package riscv_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DROP
   } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr,pc} holding buffer for a fetched word
// that could not enter IF/ID in the cycle it returned.
module fetch_skid_buf #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            clear,
   input  logic [31:0]     wr_instr,
   input  logic [XLEN-1:0] wr_pc,
   output logic            valid,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] pc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         instr <= '0;
         pc    <= '0;
      end else begin
         if (clear)
            valid <= 1'b0;
         else if (load)
            valid <= 1'b1;
         if (load) begin
            instr <= wr_instr;
            pc    <= wr_pc;
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage with IF/ID register: owns the PC, keeps at most one
// fetch in flight, and feeds decode with words or NOP bubbles.
module fetch_stage #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_IF,
   input  logic            stall_ID,
   input  logic            flush_ID,
   input  logic            PCSrc_EX,
   input  logic [XLEN-1:0] PCTarget_EX,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic [31:0]     instr_ID,
   output logic [XLEN-1:0] pc_ID,
   output logic [XLEN-1:0] pc_plus4_ID,
   output logic            valid_ID
);

   import riscv_pkg::fetch_state_t;
   import riscv_pkg::IDLE;
   import riscv_pkg::WAIT;
   import riscv_pkg::DROP;

   fetch_state_t    state;
   logic [XLEN-1:0] pc_IF;
   logic [XLEN-1:0] pc_req;
   logic            buf_valid;
   logic [31:0]     buf_instr;
   logic [XLEN-1:0] buf_pc;
   logic            fire;
   logic            rsp_take;
   logic            buf_load;
   logic            buf_clear;

   assign imem_req_valid = (state == IDLE) & ~buf_valid
                         & ~stall_IF & ~PCSrc_EX;
   assign imem_addr = pc_IF;
   assign fire      = imem_req_valid & imem_req_ready;
   // A redirect in the return cycle makes the word stale.
   assign rsp_take  = (state == WAIT) & imem_rsp_valid & ~PCSrc_EX;
   assign buf_load  = rsp_take & (stall_ID | flush_ID);
   assign buf_clear = PCSrc_EX | (buf_valid & ~flush_ID & ~stall_ID);

   fetch_skid_buf #(.XLEN(XLEN)) u_skid (
      .clk      (clk),
      .rst      (rst),
      .load     (buf_load),
      .clear    (buf_clear),
      .wr_instr (imem_rsp_data),
      .wr_pc    (pc_req),
      .valid    (buf_valid),
      .instr    (buf_instr),
      .pc       (buf_pc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         pc_IF  <= RESET_PC;
         pc_req <= '0;
      end else begin
         if (PCSrc_EX)
            pc_IF <= PCTarget_EX;
         else if (fire)
            pc_IF <= pc_IF + XLEN'(4);
         if (fire)
            pc_req <= pc_IF;
         case (state)
            IDLE: if (fire) state <= WAIT;
            WAIT: begin
               if (imem_rsp_valid)
                  state <= IDLE;
               else if (PCSrc_EX)
                  state <= DROP;
            end
            DROP: if (imem_rsp_valid) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_ID    <= NOP_INSTR;
         pc_ID       <= '0;
         pc_plus4_ID <= '0;
         valid_ID    <= 1'b0;
      end else if (flush_ID) begin
         instr_ID <= NOP_INSTR;
         valid_ID <= 1'b0;
      end else if (stall_ID) begin
         valid_ID <= valid_ID;
      end else if (buf_valid) begin
         instr_ID    <= buf_instr;
         pc_ID       <= buf_pc;
         pc_plus4_ID <= buf_pc + XLEN'(4);
         valid_ID    <= 1'b1;
      end else if (rsp_take) begin
         instr_ID    <= imem_rsp_data;
         pc_ID       <= pc_req;
         pc_plus4_ID <= pc_req + XLEN'(4);
         valid_ID    <= 1'b1;
      end else begin
         instr_ID <= NOP_INSTR;
         valid_ID <= 1'b0;
      end
   end

   // Memory must be reset with the core; no response may land in IDLE.
   a_no_idle_rsp: assert property (@(posedge clk) disable iff (rst)
      !(state == IDLE && imem_rsp_valid));

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench: expected program-order PC stream vs. words
// delivered to ID, plus directed checks of stall/flush/redirect.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_IF, stall_ID, flush_ID, PCSrc_EX;
   logic [31:0] PCTarget_EX;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] instr_ID, pc_ID, pc_plus4_ID;
   logic        valid_ID;

   fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .stall_IF       (stall_IF),
      .stall_ID       (stall_ID),
      .flush_ID       (flush_ID),
      .PCSrc_EX       (PCSrc_EX),
      .PCTarget_EX    (PCTarget_EX),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr_ID       (instr_ID),
      .pc_ID          (pc_ID),
      .pc_plus4_ID    (pc_plus4_ID),
      .valid_ID       (valid_ID)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] NOP = 32'h0000_0013;

   int n_chk = 0;
   int n_fail = 0;
   int deliveries = 0;
   int cyc = 0;
   int lat_fix = 0;
   int ready_mode = 1;
   logic [31:0] exp_q[$];
   logic [31:0] next_pc = 0;
   logic [31:0] acc_q[$];
   int          acc_c[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic redirect_model(input logic [31:0] t);
      exp_q.delete();
      next_pc = t;
      while (exp_q.size() < 16) begin
         exp_q.push_back(next_pc);
         next_pc = next_pc + 32'd4;
      end
   endtask

   always @(negedge clk)
      while (exp_q.size() < 16) begin
         exp_q.push_back(next_pc);
         next_pc = next_pc + 32'd4;
      end

   // Instruction memory: one request in flight, latency lat_fix or random.
   initial begin
      logic        pending;
      logic [31:0] paddr;
      int          cnt;
      pending = 0; paddr = 0; cnt = 0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            pending = 0;
         end else begin
            if (imem_rsp_valid) pending = 0;
            if (imem_req_valid && imem_req_ready) begin
               pending = 1;
               paddr = imem_addr;
               cnt = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
               acc_q.push_back(imem_addr);
               acc_c.push_back(cyc);
            end
         end
         #1;
         if (pending && cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(paddr);
         end else begin
            imem_rsp_valid = 1'b0;
            if (pending) cnt--;
         end
         imem_req_ready = (ready_mode == 1) ? 1'b1 :
                          (ready_mode == 2) ? 1'b0 :
                          1'($urandom_range(0, 1));
      end
   end

   // Monitor: every fresh load of IF/ID must be the next program-order word.
   initial begin
      logic s, f, r;
      logic [31:0] e;
      forever begin
         @(posedge clk);
         s = stall_ID; f = flush_ID; r = rst;
         #1;
         if (!r && !rst && !s && !f && valid_ID) begin
            deliveries++;
            if (exp_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL sb_empty: delivered pc %h", pc_ID);
            end else begin
               e = exp_q.pop_front();
               chk("sb_pc", pc_ID, e);
               chk("sb_instr", instr_ID, mem_word(e));
               chk("sb_pc4", pc_plus4_ID, e + 32'd4);
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      stall_IF = 0; stall_ID = 0; flush_ID = 0; PCSrc_EX = 0;
      PCTarget_EX = '0;
      repeat (2) @(negedge clk);
      exp_q.delete();
      next_pc = 0;
      redirect_model(32'h0);
      acc_q.delete();
      acc_c.delete();
      rst = 1'b0;
   endtask

   task automatic wait_acc(input int n, input string name);
      int k;
      k = 0;
      while (acc_q.size() < n && k < 60) begin
         @(negedge clk);
         k++;
      end
      if (acc_q.size() < n) begin
         n_chk++; n_fail++;
         $display("FAIL %s: accepts %0d required %0d", name, acc_q.size(), n);
      end
   endtask

   task automatic redirect(input logic [31:0] t);
      PCSrc_EX = 1'b1; flush_ID = 1'b1; PCTarget_EX = t;
      redirect_model(t);
      @(negedge clk);
      PCSrc_EX = 1'b0; flush_ID = 1'b0;
   endtask

   initial begin
      int n, k, d0;
      rst = 1'b1;
      stall_IF = 0; stall_ID = 0; flush_ID = 0; PCSrc_EX = 0;
      PCTarget_EX = '0;
      repeat (2) @(negedge clk);
      chk("rst_instr", instr_ID, NOP);
      chk("rst_valid", 32'(valid_ID), 0);
      chk("rst_pc", pc_ID, 0);
      chk("rst_pc4", pc_plus4_ID, 0);
      chk("rst_addr", imem_addr, 0);

      // Back-to-back fetches with single-cycle memory
      lat_fix = 0; ready_mode = 1;
      do_reset();
      wait_acc(3, "seq_wait");
      chk("seq_a0", acc_q[0], 32'h0);
      chk("seq_a1", acc_q[1], 32'h4);
      chk("seq_a2", acc_q[2], 32'h8);
      chk("seq_gap1", 32'(acc_c[1] - acc_c[0]), 2);
      chk("seq_gap2", 32'(acc_c[2] - acc_c[1]), 2);
      chk("seq_bubble", 32'(valid_ID), 0);
      @(negedge clk);
      chk("seq_v8", 32'(valid_ID), 1);
      chk("seq_pc8", pc_ID, 32'h8);

      // stall_ID while the word for 0x4 returns
      do_reset();
      wait_acc(2, "stl_wait");
      stall_ID = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stl_hold", instr_ID, NOP);
         chk("stl_noreq", 32'(imem_req_valid), 0);
      end
      stall_ID = 1'b0;
      @(negedge clk);
      chk("stl_pc4", pc_ID, 32'h4);
      chk("stl_v", 32'(valid_ID), 1);
      chk("stl_instr", instr_ID, mem_word(32'h4));
      chk("stl_next", imem_addr, 32'h8);

      // Redirect while 0x8 is outstanding
      lat_fix = 3;
      do_reset();
      wait_acc(3, "rd_wait");
      redirect(32'h100);
      chk("rd_drop_noreq", 32'(imem_req_valid), 0);
      chk("rd_bubble", 32'(valid_ID), 0);
      wait_acc(4, "rd_wait2");
      chk("rd_addr", acc_q[3], 32'h100);
      chk("rd_bubble2", 32'(valid_ID), 0);
      k = 0;
      while (!valid_ID && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("rd_pc", pc_ID, 32'h100);

      // flush and stall together: flush wins
      flush_ID = 1'b1; stall_ID = 1'b1;
      @(negedge clk);
      flush_ID = 1'b0; stall_ID = 1'b0;
      chk("fl_instr", instr_ID, NOP);
      chk("fl_valid", 32'(valid_ID), 0);
      chk("fl_pchold", pc_ID, 32'h100);
      chk("fl_pc4hold", pc_plus4_ID, 32'h104);

      // stall_IF with memory not ready, then redirect under stall_IF
      lat_fix = 0;
      stall_IF = 1'b1; ready_mode = 2;
      repeat (6) @(negedge clk);
      chk("sif_noreq", 32'(imem_req_valid), 0);
      n = int'(imem_addr);
      @(negedge clk);
      chk("sif_pchold", imem_addr, 32'(n));
      redirect(32'h200);
      chk("sif_target", imem_addr, 32'h200);
      stall_IF = 1'b0; ready_mode = 1;

      // PC wrap at the top of the address space
      redirect(32'hFFFF_FFFC);
      n = acc_q.size();
      wait_acc(n + 1, "wrap_wait");
      chk("wrap_req", acc_q[$], 32'hFFFF_FFFC);
      chk("wrap_pc", imem_addr, 32'h0);

      // Reset asserted while a fetch is outstanding
      lat_fix = 4;
      n = acc_q.size();
      wait_acc(n + 1, "rstw_wait");
      rst = 1'b1;
      #1;
      chk("rstw_instr", instr_ID, NOP);
      chk("rstw_valid", 32'(valid_ID), 0);
      chk("rstw_pc", pc_ID, 0);
      chk("rstw_pc4", pc_plus4_ID, 0);
      chk("rstw_addr", imem_addr, 0);

      // Random traffic against the program-order scoreboard
      lat_fix = -1; ready_mode = 0;
      do_reset();
      d0 = deliveries;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         stall_ID = ($urandom_range(0, 3) == 0);
         stall_IF = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 19) == 0) begin
            PCSrc_EX = 1'b1; flush_ID = 1'b1;
            PCTarget_EX = {$urandom_range(0, 32'h3FFF_FFFF) , 2'b00} ;
            redirect_model(PCTarget_EX);
         end else begin
            PCSrc_EX = 1'b0; flush_ID = 1'b0;
         end
      end
      @(negedge clk);
      PCSrc_EX = 0; flush_ID = 0; stall_ID = 0; stall_IF = 0;
      repeat (10) @(negedge clk);
      n_chk++;
      if (deliveries - d0 < 150) begin
         n_fail++;
         $display("FAIL rand_progress: delivered %0d required >=150",
                  deliveries - d0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
